// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue/writeback slice.
// Widths, yAlu op codes and the register-address type.
package alu_pkg;

  localparam int XLEN_D = 32;
  localparam int RAW_D  = 5;
  localparam int OPW    = 3;

  localparam logic [OPW-1:0] OP_AND = 3'b000;
  localparam logic [OPW-1:0] OP_OR  = 3'b001;
  localparam logic [OPW-1:0] OP_ADD = 3'b010;
  localparam logic [OPW-1:0] OP_SUB = 3'b110;
  localparam logic [OPW-1:0] OP_SLT = 3'b111;

  typedef logic [RAW_D-1:0] reg_addr_t;

endpackage

// File: rtl/alu_regfile.sv
// 2**RAW x XLEN register file: two read ports, one debug read port,
// one synchronous write port. r0 reads 0 and ignores writes.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int RAW  = RAW_D
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RAW-1:0]  ra_addr,
  output logic [XLEN-1:0] ra_data,
  input  logic [RAW-1:0]  rb_addr,
  output logic [XLEN-1:0] rb_data,
  input  logic [RAW-1:0]  dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  input  logic            we,
  input  logic [RAW-1:0]  wa,
  input  logic [XLEN-1:0] wd
);

  localparam int N = 1 << RAW;

  logic [XLEN-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (we && wa != '0) begin
      mem[wa] <= wd;
    end
  end

  assign ra_data  = (ra_addr  == '0) ? '0 : mem[ra_addr];
  assign rb_data  = (rb_addr  == '0) ? '0 : mem[rb_addr];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Operand issue + writeback around an external yAlu: E stage drives
// alu_a/b/op, W stage holds the retired result on the out_* stream.
// Ports: in_* instruction handshake, ld_* preload, alu_* to/from yAlu,
// out_* result handshake, dbg_* register-file peek.
module alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int RAW  = RAW_D
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_op,
  input  logic [RAW-1:0]  in_rs,
  input  logic [RAW-1:0]  in_rt,
  input  logic [RAW-1:0]  in_rd,
  input  logic            ld_valid,
  input  logic [RAW-1:0]  ld_addr,
  input  logic [XLEN-1:0] ld_data,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [OPW-1:0]  alu_op,
  input  logic [XLEN-1:0] alu_z,
  input  logic            alu_ex,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RAW-1:0]  out_rd,
  output logic [XLEN-1:0] out_z,
  output logic            out_ex,
  input  logic [RAW-1:0]  dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  logic            e_valid;
  logic [RAW-1:0]  e_rd;
  logic            adv;
  logic            accept;
  logic            wb;
  logic            pl;
  logic            we;
  logic [RAW-1:0]  wa;
  logic [XLEN-1:0] wd;
  logic [XLEN-1:0] rf_a;
  logic [XLEN-1:0] rf_b;
  logic [XLEN-1:0] opnd_a;
  logic [XLEN-1:0] opnd_b;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  // Writeback owns the port; preload only fills idle slots.
  assign wb = adv && e_valid;
  assign pl = adv && ld_valid && !e_valid && !accept;
  assign we = wb || pl;
  assign wa = wb ? e_rd  : ld_addr;
  assign wd = wb ? alu_z : ld_data;

  alu_regfile #(.XLEN(XLEN), .RAW(RAW)) u_rf (
    .clk      (clk),
    .reset    (reset),
    .ra_addr  (in_rs),
    .ra_data  (rf_a),
    .rb_addr  (in_rt),
    .rb_data  (rf_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (we),
    .wa       (wa),
    .wd       (wd)
  );

  // Result in E is written this edge, so bypass it; r0 wins over all.
  always_comb begin
    opnd_a = rf_a;
    if (e_valid && adv && e_rd == in_rs) opnd_a = alu_z;
    if (in_rs == '0) opnd_a = '0;
    opnd_b = rf_b;
    if (e_valid && adv && e_rd == in_rt) opnd_b = alu_z;
    if (in_rt == '0) opnd_b = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid   <= 1'b0;
      e_rd      <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      out_valid <= 1'b0;
      out_rd    <= '0;
      out_z     <= '0;
      out_ex    <= 1'b0;
    end else if (adv) begin
      e_valid <= accept;
      if (accept) begin
        alu_op <= in_op;
        alu_a  <= opnd_a;
        alu_b  <= opnd_b;
        e_rd   <= in_rd;
      end
      out_valid <= e_valid;
      if (e_valid) begin
        out_z  <= alu_z;
        out_ex <= alu_ex;
        out_rd <= e_rd;
      end
    end
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Operand-issue and writeback stage directly upstream of `yAlu`. It accepts register-form ALU instructions over a valid/ready handshake and reads two operands from a 32×32 register file, forwarding a result still in flight when needed. It drives `yAlu`'s `a`/`b`/`op` inputs from registers, captures `z`/`ex` one cycle later, writes the result back and presents it on a result stream. `yAlu` is instantiated beside this block, not inside it.

## Interface
- `XLEN`, 32, datapath width (matches `yAlu`)
- `RAW`, 5, register address width (32 registers)

- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `in_valid` in 1, `in_ready` out 1: instruction handshake
- `in_op` in 3: `yAlu` op code
- `in_rs`, `in_rt`, `in_rd` in RAW: source A, source B, destination
- `ld_valid` in 1, `ld_addr` in RAW, `ld_data` in XLEN: register preload port
- `alu_a`, `alu_b` out XLEN, `alu_op` out 3: registered, to `yAlu`
- `alu_z` in XLEN, `alu_ex` in 1: combinational results from `yAlu`
- `out_valid` in/out: `out_valid` out 1, `out_ready` in 1: result handshake
- `out_rd` out RAW, `out_z` out XLEN, `out_ex` out 1: retired result
- `dbg_addr` in RAW, `dbg_data` out XLEN: combinational register-file peek, no forwarding

## Operation
- Two stages: E (operands on `alu_*`, `e_valid`, `e_rd`) and W (`out_*` register).
- Global stall: `adv = !out_valid || out_ready`; `in_ready = adv`. When `adv` = 0, E, W and the register file all hold.
- Accept (`in_valid && in_ready`): E loads `alu_op = in_op`, `alu_a = opnd(in_rs)`, `alu_b = opnd(in_rt)`, `e_rd = in_rd`, `e_valid = 1`. Otherwise, when `adv` = 1, `e_valid` clears. `alu_a`/`alu_b`/`alu_op` keep their last values when E is empty.
- `opnd(r)`: 0 if r = 0; `alu_z` if `e_valid && adv && e_rd == r`; else `rf[r]`.
- When `adv` is high and `e_valid` is set:
  - W loads `out_z = alu_z`, `out_ex = alu_ex`, `out_rd = e_rd`, `out_valid = 1`.
  - `rf[e_rd] <= alu_z` unless `e_rd` = 0.
- When `adv` is high and `e_valid` is clear, `out_valid` clears.
- r0 reads as 0 always; writes to r0 are suppressed for both writeback and preload.
- Ops are passed through unchecked: `000` AND, `001` OR, `010` ADD, `110` SUB, `111` SLT. Any other code still issues and writes back whatever `yAlu` returns.
- Preload: `rf[ld_addr] <= ld_data` only when `ld_valid && !e_valid && !(in_valid && in_ready)`. Otherwise the preload is ignored with no error.
- Reset:
  - every `rf` entry is cleared to 0;
  - `e_valid`, `out_valid`, `alu_a`, `alu_b`, `alu_op`, `out_rd`, `out_z` and `out_ex` are cleared to 0;
  - `in_ready` = 1 after reset.
- Reset mid-flight discards E and W contents with no register-file write. Reset has priority over every other event in the same cycle.

## Timing
- Accept at edge N puts operands on `alu_*` after edge N. The result is captured and written back at edge N+1, so `out_valid` is high after edge N+1. Latency is 2 edges; throughput is 1 instruction per cycle with no stalls.
- A dependent instruction accepted at edge N+1 gets `alu_z` forwarded. Dependencies two or more apart read the register file, which is already written.
- `out_*` stay stable while `out_valid && !out_ready`. The result leaves on the first edge with `out_ready` = 1.
- `dbg_data` reflects writes from the following cycle onward.

## Structure
- Package `alu_pkg`:
  - `XLEN_D = 32`, `RAW_D = 5`
  - op constants `OP_AND`, `OP_OR`, `OP_ADD`, `OP_SUB`, `OP_SLT`
  - typedef `reg_addr_t`
- Sub-module `alu_regfile`: 2 combinational read ports, 1 debug read port, 1 synchronous write port with r0 suppression, synchronous clear on `reset`.
- The issue module arbitrates the write port between writeback and preload, and owns the forwarding mux, the E/W registers and the stall logic.

## Test plan
- Reset, then scan `dbg_addr` over 0..31: all `dbg_data` = 0; `out_valid` = 0; `alu_a` = `alu_b` = 0, `alu_op` = 0; `in_ready` = 1.
- Preload r1 = 7 and r2 = 5, then issue ADD rd=3 rs=1 rt=2: after 2 edges `out_valid` = 1, `out_z` = 12, `out_rd` = 3; `dbg` r3 = 12.
- ADD r3 = r1 + r2, then SUB r4 = r3 − r1 on the next cycle: forwarded operand gives `out_z` = 5; then AND r5 = r4 & r1 gives 5, and OR gives 7.
- ADD rd=0 rs=1 rt=2: `out_z` = 12, `out_rd` = 0; `dbg` r0 = 0; a following ADD rs=0 rt=2 gives 5.
- Hold `out_ready` = 0 for 3 cycles with 3 queued instructions:
  - `in_ready` = 0 during the hold;
  - `out_*` are stable;
  - results then retire in order with none lost or duplicated;
  - a preload attempted while E is busy is ignored.
- Assert `reset` while E and W are valid: next cycle `out_valid` = 0 and `e_valid` = 0; the target register still reads 0.
